// File: rtl/cgra_cfg_pkg.sv
// Shared types and width helpers for the CGRA configuration stream memory.
package cgra_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  function automatic int shift_of(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int idx_width_of(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w_sync.sv
// One-write one-read synchronous RAM with one cycle of read latency.
module bsg_mem_1r1w_sync #(
  parameter int width_p = 64,
  parameter int els_p   = 1024
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       w_v_i,
  input  logic [$clog2(els_p)-1:0]   w_addr_i,
  input  logic [width_p-1:0]         w_data_i,
  input  logic                       r_v_i,
  input  logic [$clog2(els_p)-1:0]   r_addr_i,
  output logic [width_p-1:0]         r_data_o
);

  logic [width_p-1:0] mem [els_p];
  logic               unused_reset;

  assign unused_reset = reset_i;

  always_ff @(posedge clk_i) begin
    if (w_v_i) mem[w_addr_i] <= w_data_i;
    if (r_v_i) r_data_o <= mem[r_addr_i];
  end

endmodule

// File: rtl/cgra_cfg_skid_fifo.sv
// Two-entry valid/ready output buffer; upstream only pushes when a slot is guaranteed free.
module cgra_cfg_skid_fifo #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != 2'd0);
  assign do_pop  = valid && ready;
  assign do_push = push && !flush;
  // Empty buffer presents zero so the data output reads as zero after reset.
  assign data    = valid ? slot[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slot[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cgra_cfg_stream_mem.sv
// Config memory with a burst read engine streaming words on a valid/ready channel.
module cgra_cfg_stream_mem
  import cgra_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tb_we,
  input  logic [ADDR_WIDTH-1:0] tb_waddr,
  input  logic [DATA_WIDTH-1:0] tb_wdata,
  input  logic                  ld_req_v,
  output logic                  ld_req_ready,
  input  logic [ADDR_WIDTH-1:0] ld_base_addr,
  input  logic [LEN_WIDTH-1:0]  ld_len,
  input  logic                  ld_abort,
  output logic [DATA_WIDTH-1:0] cfg_data,
  output logic                  cfg_valid,
  input  logic                  cfg_ready,
  output logic                  cfg_last,
  output logic                  busy,
  output logic                  err
);

  localparam int SHIFT = shift_of(DATA_WIDTH);
  localparam int IDX_W = idx_width_of(DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0]     idx;
    logic [LEN_WIDTH-1:0] len;
  } burst_t;

  state_e                 state;
  burst_t                 burst;
  logic [LEN_WIDTH-1:0]   issued;
  logic [IDX_W-1:0]       widx;
  logic [IDX_W-1:0]       req_idx;
  logic                   req_fire;
  logic                   req_bad;
  logic                   pop;
  logic                   hazard;
  logic                   room;
  logic                   vld_p0;
  logic                   last_p0;
  logic                   vld_p1;
  logic                   last_p1;
  logic [DATA_WIDTH-1:0]  ram_data_p1;
  logic [1:0]             buf_count;
  logic                   abort_now;
  logic                   unused_addr;

  assign widx         = tb_waddr[SHIFT +: IDX_W];
  assign req_idx      = ld_base_addr[SHIFT +: IDX_W];
  assign unused_addr  = ^{tb_waddr[ADDR_WIDTH-1:SHIFT+IDX_W], tb_waddr[SHIFT-1:0],
                          ld_base_addr[ADDR_WIDTH-1:SHIFT+IDX_W]};

  assign ld_req_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign req_fire     = ld_req_v && ld_req_ready;
  assign req_bad      = (ld_base_addr[SHIFT-1:0] != '0) || (ld_len == '0);
  assign pop          = cfg_valid && cfg_ready;
  assign abort_now    = ld_abort && (state != IDLE);

  // Stage p0: read issue. A same-cycle write to the index being read wins; the read waits a cycle.
  assign hazard  = tb_we && (widx == burst.idx);
  assign room    = (3'(buf_count) + 3'(vld_p1) - 3'(pop)) < 3'd2;
  assign vld_p0  = (state == STREAM) && !ld_abort && !hazard && room && (issued != burst.len);
  assign last_p0 = (issued == burst.len - LEN_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      burst   <= '0;
      issued  <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      err     <= 1'b0;
    end else begin
      err     <= 1'b0;
      vld_p1  <= vld_p0;
      last_p1 <= vld_p0 && last_p0;
      case (state)
        IDLE: begin
          if (req_fire) begin
            if (req_bad) begin
              err <= 1'b1;
            end else begin
              burst  <= '{idx: req_idx, len: ld_len};
              issued <= '0;
              state  <= STREAM;
            end
          end
        end
        STREAM: begin
          if (ld_abort) begin
            state <= IDLE;
          end else if (vld_p0) begin
            burst.idx <= burst.idx + IDX_W'(1);
            issued    <= issued + LEN_WIDTH'(1);
            if (last_p0) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (ld_abort) state <= IDLE;
          else if (pop && cfg_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  bsg_mem_1r1w_sync #(
    .width_p (DATA_WIDTH),
    .els_p   (DEPTH)
  ) u_ram (
    .clk_i    (clk),
    .reset_i  (~rst_n),
    .w_v_i    (tb_we),
    .w_addr_i (widx),
    .w_data_i (tb_wdata),
    .r_v_i    (vld_p0),
    .r_addr_i (burst.idx),
    .r_data_o (ram_data_p1)
  );

  // Stage p1: RAM output lands in the output buffer; an abort drops it along with the buffer.
  cgra_cfg_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort_now),
    .push      (vld_p1),
    .push_data ({last_p1, ram_data_p1}),
    .ready     (cfg_ready),
    .valid     (cfg_valid),
    .data      ({cfg_last, cfg_data}),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_cgra_cfg_stream_mem.sv
// Directed bench for the config stream memory: latency, backpressure, wrap, errors, hazard, abort, reset.
module tb_cgra_cfg_stream_mem;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int DP = 1024;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_waddr = '0;
  logic [DW-1:0] tb_wdata = '0;
  logic          ld_req_v = 1'b0;
  logic          ld_req_ready;
  logic [AW-1:0] ld_base_addr = '0;
  logic [LW-1:0] ld_len = '0;
  logic          ld_abort = 1'b0;
  logic [DW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready = 1'b1;
  logic          cfg_last;
  logic          busy;
  logic          err;

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] exp_words [16];
  logic          pat [4];

  cgra_cfg_stream_mem #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DP),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tb_we        (tb_we),
    .tb_waddr     (tb_waddr),
    .tb_wdata     (tb_wdata),
    .ld_req_v     (ld_req_v),
    .ld_req_ready (ld_req_ready),
    .ld_base_addr (ld_base_addr),
    .ld_len       (ld_len),
    .ld_abort     (ld_abort),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_last     (cfg_last),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input int idx, input logic [DW-1:0] data);
    tb_we    = 1'b1;
    tb_waddr = AW'(idx * 8);
    tb_wdata = data;
    tick();
    tb_we    = 1'b0;
  endtask

  task automatic req(input logic [AW-1:0] base, input logic [LW-1:0] len);
    ld_req_v     = 1'b1;
    ld_base_addr = base;
    ld_len       = len;
    tick();
    ld_req_v     = 1'b0;
  endtask

  // Accepts n words against exp_words; optionally writes 0xDEAD to index 5 at loop cycle wr_cycle.
  task automatic collect(input int n, input int len, input bit toggle, input int wr_cycle,
                         input string tag);
    int            got = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    for (int c = 0; c < 64 && got < n; c++) begin
      cfg_ready = toggle ? pat[c[1:0]] : 1'b1;
      if (c == wr_cycle) begin
        tb_we    = 1'b1;
        tb_waddr = AW'(5 * 8);
        tb_wdata = 64'hDEAD;
      end else begin
        tb_we = 1'b0;
      end
      if (prev_stall) begin
        chk({tag, " hold valid"}, 64'(cfg_valid), 64'd1);
        chk({tag, " hold data"}, cfg_data, prev_data);
      end
      prev_stall = cfg_valid && !cfg_ready;
      prev_data  = cfg_data;
      if (cfg_valid && cfg_ready) begin
        chk({tag, " data"}, cfg_data, exp_words[got]);
        chk({tag, " last"}, 64'(cfg_last), 64'(got == len - 1));
        got++;
      end
      tick();
    end
    tb_we     = 1'b0;
    cfg_ready = 1'b1;
    chk({tag, " count"}, 64'(got), 64'(n));
  endtask

  initial begin
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst ld_req_ready", 64'(ld_req_ready), 64'd1);
    chk("rst cfg_valid", 64'(cfg_valid), 64'd0);
    chk("rst cfg_last", 64'(cfg_last), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst cfg_data", cfg_data, 64'd0);
    tick();
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) write_word(i, DW'(32'hA000 + i));

    // Test 1: base 0, len 4, full rate, exact latency
    for (int i = 0; i < 4; i++) exp_words[i] = DW'(32'hA000 + i);
    req(32'h0, 8'd4);
    chk("t1 busy E0+1", 64'(busy), 64'd1);
    chk("t1 ready E0+1", 64'(ld_req_ready), 64'd0);
    tick();
    chk("t1 valid E0+2", 64'(cfg_valid), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t1 valid", 64'(cfg_valid), 64'd1);
      chk("t1 data", cfg_data, exp_words[i]);
      chk("t1 last", 64'(cfg_last), 64'(i == 3));
      chk("t1 busy", 64'(busy), 64'd1);
      tick();
    end
    chk("t1 busy after", 64'(busy), 64'd0);
    chk("t1 valid after", 64'(cfg_valid), 64'd0);

    // Test 2: same burst with toggling ready
    req(32'h0, 8'd4);
    collect(4, 4, 1'b1, -1, "t2");
    chk("t2 busy after", 64'(busy), 64'd0);

    // Test 3: burst wraps from index 1023 to 0
    write_word(1022, 64'hB3FE);
    write_word(1023, 64'hB3FF);
    exp_words[0] = 64'hB3FE; exp_words[1] = 64'hB3FF;
    exp_words[2] = 64'hA000; exp_words[3] = 64'hA001;
    req(32'h1FF0, 8'd4);
    collect(4, 4, 1'b0, -1, "t3");
    chk("t3 busy after", 64'(busy), 64'd0);

    // Test 4: rejected requests, then a good one
    req(32'h4, 8'd4);
    chk("t4 misalign err", 64'(err), 64'd1);
    chk("t4 misalign busy", 64'(busy), 64'd0);
    tick();
    chk("t4 err pulse end", 64'(err), 64'd0);
    chk("t4 no valid", 64'(cfg_valid), 64'd0);
    req(32'h0, 8'd0);
    chk("t4 len0 err", 64'(err), 64'd1);
    tick();
    chk("t4 len0 err end", 64'(err), 64'd0);
    chk("t4 len0 busy", 64'(busy), 64'd0);
    exp_words[0] = 64'hA001; exp_words[1] = 64'hA002;
    req(32'h8, 8'd2);
    collect(2, 2, 1'b0, -1, "t4");

    // Test 5: write to index 5 in its issue cycle
    for (int i = 0; i < 8; i++) exp_words[i] = DW'(32'hA000 + i);
    exp_words[5] = 64'hDEAD;
    req(32'h0, 8'd8);
    collect(8, 8, 1'b0, 5, "t5");
    chk("t5 busy after", 64'(busy), 64'd0);

    // Test 6a: abort after three words
    for (int i = 0; i < 8; i++) exp_words[i] = DW'(32'hA000 + i);
    req(32'h0, 8'd8);
    collect(3, 8, 1'b0, -1, "t6a");
    ld_abort  = 1'b1;
    cfg_ready = 1'b0;
    tick();
    ld_abort  = 1'b0;
    cfg_ready = 1'b1;
    chk("t6a valid", 64'(cfg_valid), 64'd0);
    chk("t6a busy", 64'(busy), 64'd0);
    chk("t6a last", 64'(cfg_last), 64'd0);
    chk("t6a req_ready", 64'(ld_req_ready), 64'd1);
    tick();
    tick();
    chk("t6a valid later", 64'(cfg_valid), 64'd0);
    exp_words[0] = 64'hA002; exp_words[1] = 64'hA003; exp_words[2] = 64'hA004;
    req(32'h10, 8'd3);
    collect(3, 3, 1'b0, -1, "t6a next");
    chk("t6a next busy", 64'(busy), 64'd0);

    // Test 6b: reset mid-burst
    req(32'h0, 8'd8);
    tick();
    tick();
    chk("t6b valid before rst", 64'(cfg_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6b valid", 64'(cfg_valid), 64'd0);
    chk("t6b busy", 64'(busy), 64'd0);
    chk("t6b req_ready", 64'(ld_req_ready), 64'd1);
    chk("t6b data", cfg_data, 64'd0);
    chk("t6b last", 64'(cfg_last), 64'd0);
    chk("t6b err", 64'(err), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    exp_words[0] = 64'hA006; exp_words[1] = 64'hA007;
    req(32'h30, 8'd2);
    collect(2, 2, 1'b0, -1, "t6b next");
    chk("t6b next busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
